// File: rtl/serial_pattern_feeder.sv
// Serial pattern player: shifts a captured 1-16 bit pattern out MSB-first,
// one bit per divider period, with one-shot or continuous playback.
module serial_pattern_feeder #(
   parameter int DIV_WIDTH = 26,
   parameter int DIV_COUNT = 49_999_999
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [15:0] pattern,
   input  logic [4:0]  len,
   input  logic        start,
   input  logic        repeat_en,
   input  logic        abort,
   output logic        w_out,
   output logic        bit_strobe,
   output logic [3:0]  bit_index,
   output logic        busy,
   output logic        done
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [15:0]            image_q, image_d;
   logic [15:0]            captured_q, captured_d;
   logic [4:0]             len_q, len_d;
   logic [4:0]             sent_q, sent_d;
   logic                   w_out_q, w_out_d;
   logic                   strobe_q, strobe_d;
   logic [3:0]             index_q, index_d;
   logic                   done_q, done_d;

   logic [4:0]             len_c;
   logic [15:0]            image_load;
   logic                   tick;

   assign len_c      = (len > 5'd16) ? 5'd16 : len;
   assign image_load = pattern << (5'd16 - len_c);
   assign tick       = (div_q == DIV_WIDTH'(DIV_COUNT));

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         image_q    <= '0;
         captured_q <= '0;
         len_q      <= '0;
         sent_q     <= '0;
         w_out_q    <= 1'b0;
         strobe_q   <= 1'b0;
         index_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         image_q    <= image_d;
         captured_q <= captured_d;
         len_q      <= len_d;
         sent_q     <= sent_d;
         w_out_q    <= w_out_d;
         strobe_q   <= strobe_d;
         index_q    <= index_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      image_d    = image_q;
      captured_d = captured_q;
      len_d      = len_q;
      sent_d     = sent_q;
      w_out_d    = w_out_q;
      index_d    = index_q;
      strobe_d   = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!abort && start && (len != 5'd0)) begin
               len_d      = len_c;
               image_d    = image_load;
               captured_d = image_load;
               sent_d     = '0;
               div_d      = '0;
               state_d    = S_RUN;
            end
         end

         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               w_out_d = 1'b0;
               index_d = '0;
               div_d   = '0;
               sent_d  = '0;
            end else begin
               div_d = tick ? '0 : div_q + 1'b1;
               if (tick) begin
                  if (sent_q < len_q) begin
                     w_out_d  = image_q[15];
                     image_d  = image_q << 1;
                     index_d  = sent_q[3:0];
                     sent_d   = sent_q + 5'd1;
                     strobe_d = 1'b1;
                  end else if (repeat_en) begin
                     // Wrap straight into the next pass from the captured copy.
                     w_out_d  = captured_q[15];
                     image_d  = captured_q << 1;
                     index_d  = '0;
                     sent_d   = 5'd1;
                     strobe_d = 1'b1;
                  end else begin
                     w_out_d = 1'b0;
                     index_d = '0;
                     done_d  = 1'b1;
                     state_d = S_IDLE;
                  end
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign w_out      = w_out_q;
   assign bit_strobe = strobe_q;
   assign bit_index  = index_q;
   assign busy       = (state_q == S_RUN);
   assign done       = done_q;

endmodule

// File: doc/serial_pattern_feeder.md
# serial_pattern_feeder

Upstream stimulus stage for the sequence-detector FSM. Captures a 1–16-bit pattern and plays it out MSB-first on a single serial line, one bit per divider period. The detector samples this line as its input `w`. `bit_strobe` is a one-cycle pulse marking each new bit, so the detector can use it as its advance enable instead of a manual key press. Playback is one-shot or continuous, with busy/done status for the board-level wrapper.

## Interface
- `DIV_WIDTH`, default 26: width of the period divider counter.
- `DIV_COUNT`, default 49_999_999: divider terminal value. Bit period = `DIV_COUNT`+1 clock cycles (1 s at 50 MHz).
- `clock`  in  1  system clock, all logic on rising edge.
- `resetn`  in  1  reset, synchronous, active-low; clock `clock`.
- `pattern`  in  16  pattern bits, right-justified; bit `len`-1 plays first.
- `len`  in  5  pattern length. 0 = invalid; 17–31 are clamped to 16.
- `start`  in  1  level; sampled only in IDLE.
- `repeat`  in  1  continuous playback enable, sampled live at each wrap.
- `abort`  in  1  synchronous stop, sampled every cycle.
- `w_out`  out  1  serial bit to detector.
- `bit_strobe`  out  1  high for the first cycle a new bit is on `w_out`.
- `bit_index`  out  4  0-based position of the bit currently on `w_out`; 0 in IDLE.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- **States:** IDLE and RUN. The `done` pulse is registered alongside the RUN→IDLE transition.
- **Priority per edge:** `resetn`=0, then `abort`, then normal operation.
- **Reset:**
  - all outputs 0, divider 0, state IDLE;
  - internal pattern register and counters cleared.
- **IDLE, `start`=1 and `len`≠0:**
  - capture `len_c` = min(`len`,16);
  - capture pattern left-justified into a 16-bit shift image: `pattern` << (16−`len_c`);
  - sent-count := 0, divider := 0;
  - state := RUN, `busy` := 1;
  - `w_out` stays 0 until the first tick.
- **IDLE, `start`=1 and `len`=0:** ignored; no state change.
- **RUN, divider:**
  - increments every cycle;
  - tick = divider == `DIV_COUNT`;
  - on tick, divider := 0.
- **RUN, tick with sent-count < `len_c`:**
  - `w_out` := image[15], image shifted left 1;
  - `bit_index` := sent-count, then sent-count increments;
  - `bit_strobe` := 1 for one cycle.
- **RUN, tick with sent-count == `len_c` and `repeat`=1:**
  - reload image from the captured copy (not the live `pattern` input);
  - present the first bit at this same tick, so there is no gap between passes;
  - sent-count := 1, `bit_index` := 0, `bit_strobe` pulses.
- **RUN, tick with sent-count == `len_c` and `repeat`=0:**
  - `w_out` := 0, `busy` := 0, `bit_index` := 0;
  - `done` := 1 for one cycle, state := IDLE.
  - The last bit is therefore held a full period.
- **`abort`=1 in RUN:** next edge returns to IDLE; `w_out`, `busy`, `bit_index` and divider go to 0; no `done` pulse, no `bit_strobe`.
- **`abort`=1 in IDLE:** no effect; it overrides a simultaneous `start`.
- **Live inputs during RUN:** `start`, `pattern` and `len` are ignored. `repeat` changes take effect at the next wrap tick only.
- **Arithmetic:** divider is unsigned `DIV_WIDTH` bits. sent-count is 5 bits (it must hold 16).

## Timing
- `start` sampled at edge E0:
  - `busy`=1 after E0;
  - first bit appears after edge E0+(`DIV_COUNT`+1);
  - bit k appears after E0+(k+1)(`DIV_COUNT`+1).
- One-shot end: `done` pulse, `busy`=0 and `w_out`=0 after E0+(`len_c`+1)(`DIV_COUNT`+1).
- `bit_strobe` and `done` are registered. Each is exactly one cycle wide, aligned with the first cycle of the new `w_out`/state value.
- Back-to-back runs: `start` held high through completion re-launches at the edge after `done`. There is one IDLE cycle between runs.
- `resetn` low mid-RUN: IDLE with all outputs 0 after that edge; no `done`.

## Test plan
Use `DIV_COUNT`=3 (period of 4 cycles) for simulation.

1. **Reset.** Hold `resetn`=0 for 3 cycles with `start`=1 → all outputs 0 throughout. Releasing reset with `start`=1 loads on the next edge.
2. **One-shot.** `pattern`=16'h000B, `len`=4, `repeat`=0, `start` at E0 →
   - `w_out` = 1,0,1,1 after edges E4, E8, E12, E16;
   - `bit_strobe` pulses at each, `bit_index` = 0,1,2,3;
   - `done`=1 for one cycle with `busy`=0, `w_out`=0 after E20.
3. **Repeat.** `pattern`=3'b110, `len`=3, `repeat`=1 →
   - `w_out` = 1,1,0,1,1,0… with no `done` and no gap between passes;
   - drop `repeat` during the second pass → that pass finishes, `done` pulses at the following tick.
4. **Abort.** During test 2, `abort`=1 for one cycle after E9 → IDLE, `w_out`=0, `busy`=0 at E10; no `done` pulse, no further strobes.
5. **Length bounds.**
   - `len`=0 with `start`=1 → `busy` stays 0;
   - `len`=20 with `pattern`=16'hFFFF → 16 ones, then `done` after E68.
6. **Ignored inputs mid-run.** During test 2, pulse `start` and change `pattern`/`len` → identical output sequence. Separately, `resetn`=0 mid-run → immediate IDLE, no `done`.
